cordic_phase_gen: RTL and testbench

//  AXI4-Stream phase source (initiator) for the CORDIC sin/cos core's s_axis_phase channel.

---
 rtl/cordic_phase_gen.sv | 130 +++++++++++++
 tb/tb_cordic_phase_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_phase_gen.sv
// AXI4-Stream phase-word source: bursts of start_phase + k*step, wrapped into [-PI_Q, +PI_Q].
// Latency: first beat presented the cycle after start; one beat per cycle while tready is high.
// Backpressure: tvalid/tdata hold while tready is low; tvalid is registered, not driven from tready.
module cordic_phase_gen #(
    parameter int PHASE_W = 16,
    parameter int FRAC_W  = 13,
    parameter int PI_Q    = 25736,
    parameter int TDATA_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PHASE_W-1:0] start_phase,
    input  logic [PHASE_W-1:0] step,
    input  logic [CNT_W-1:0]   num_samples,
    input  logic               abort,
    output logic               m_axis_phase_tvalid,
    input  logic               m_axis_phase_tready,
    output logic [TDATA_W-1:0] m_axis_phase_tdata,
    output logic               busy,
    output logic               done
);

    // PI_Q must be pi in the FRAC_W format, and the phase word must fit in tdata.
    if (PI_Q < (3 << FRAC_W) || PI_Q > (4 << FRAC_W)) begin : g_bad_pi
        $error("cordic_phase_gen: PI_Q does not match FRAC_W");
    end
    if (TDATA_W < PHASE_W) begin : g_bad_tdata
        $error("cordic_phase_gen: TDATA_W must be >= PHASE_W");
    end

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // One extra bit so phase + step and the +/-pi limits never overflow.
    localparam logic signed [PHASE_W:0] PI_W     = (PHASE_W + 1)'(PI_Q);
    localparam logic signed [PHASE_W:0] NEG_PI_W = -PI_W;
    localparam logic signed [PHASE_W:0] TWO_PI_W = (PHASE_W + 1)'(2 * PI_Q);

    logic [0:0]                state;
    logic signed [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0]        step_q;
    logic [CNT_W-1:0]          count_q;
    logic                      tvalid_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      abort_pend;

    logic                      beat;
    logic                      last_beat;
    logic signed [PHASE_W:0]   sum;
    logic signed [PHASE_W:0]   wrapped;
    logic signed [PHASE_W:0]   sp_ext;
    logic signed [PHASE_W-1:0] phase_nxt;
    logic signed [PHASE_W-1:0] phase_init;

    assign beat      = tvalid_q && m_axis_phase_tready;
    // An abort arriving with the beat makes that beat the last one.
    assign last_beat = (count_q == CNT_W'(1)) || abort_pend || abort;

    // Next phase: add step, wrap by 2*pi once it passes +pi; saturate the start phase to +/-pi.
    always_comb begin
        sum        = $signed({phase_q[PHASE_W-1], phase_q}) + $signed({1'b0, step_q});
        wrapped    = (sum > PI_W) ? (sum - TWO_PI_W) : sum;
        phase_nxt  = wrapped[PHASE_W-1:0];
        sp_ext     = $signed({start_phase[PHASE_W-1], start_phase});
        phase_init = start_phase;
        if (sp_ext > PI_W) begin
            phase_init = PI_W[PHASE_W-1:0];
        end else if (sp_ext < NEG_PI_W) begin
            phase_init = NEG_PI_W[PHASE_W-1:0];
        end
    end

    // Burst control: IDLE waits for start, RUN presents beats until count expires or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            phase_q    <= '0;
            step_q     <= '0;
            count_q    <= '0;
            tvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (num_samples != '0) begin
                            state      <= S_RUN;
                            phase_q    <= phase_init;
                            step_q     <= step;
                            count_q    <= num_samples;
                            tvalid_q   <= 1'b1;
                            busy_q     <= 1'b1;
                            abort_pend <= 1'b0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (beat) begin
                        count_q <= count_q - CNT_W'(1);
                        phase_q <= phase_nxt;
                        if (last_beat) begin
                            state      <= S_IDLE;
                            tvalid_q   <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            abort_pend <= 1'b0;
                        end
                    end else if (abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign m_axis_phase_tvalid = tvalid_q;
    assign m_axis_phase_tdata  = TDATA_W'(phase_q);
    assign busy                = busy_q;
    assign done                = done_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
`timescale 1ns/1ps
module tb_cordic_phase_gen;

    localparam int PI_Q = 25736;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] start_phase;
    logic [15:0] step;
    logic [15:0] num_samples;
    logic        abort;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          beats    = 0;
    logic [31:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_dat   = '0;

    cordic_phase_gen dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .start_phase         (start_phase),
        .step                (step),
        .num_samples         (num_samples),
        .abort               (abort),
        .m_axis_phase_tvalid (tvalid),
        .m_axis_phase_tready (tready),
        .m_axis_phase_tdata  (tdata),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    // Scoreboard: a beat is committed at the next rising edge whenever tvalid && tready at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (!tvalid) begin
                    n_fail++;
                    $display("FAIL tvalid_drop: tvalid=%b required 1 during stall", tvalid);
                end else if (tdata !== prev_dat) begin
                    n_fail++;
                    $display("FAIL stall_hold: tdata=%0d required %0d", $signed(tdata), $signed(prev_dat));
                end
            end
            if (tvalid && tready) begin
                n_checks++;
                beats++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: tdata=%0d required no beat", $signed(tdata));
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (tdata !== e) begin
                        n_fail++;
                        $display("FAIL beat_data: tdata=%0d required %0d", $signed(tdata), $signed(e));
                    end
                end
            end
            prev_stall = tvalid && !tready;
            prev_dat   = tdata;
        end
    end

    // Reference phase sequence: saturate, then add step and wrap by 2*pi above +pi.
    function automatic void push_model(input int ph, input int st, input int n);
        int p;
        p = ph;
        if (p > PI_Q) p = PI_Q;
        if (p < -PI_Q) p = -PI_Q;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(32'(p));
            p = p + st;
            if (p > PI_Q) p = p - 2 * PI_Q;
        end
    endfunction

    // Called just after a rising edge; returns just after the edge that samples start.
    task automatic do_start(input int ph, input int st, input int n);
        start_phase = 16'(ph);
        step        = 16'(st);
        num_samples = 16'(n);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk); #1;
            if (beats >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_initial: tvalid=%b busy=%b done=%b tdata=%0d required 0 0 0 0", tvalid, busy, done, tdata);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_idle: tvalid=%b busy=%b done=%b tdata=%0d required 0 0 0 0", tvalid, busy, done, tdata);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        bit ok;
        tready = 1'b1;
        beats  = 0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd8192);
        exp_q.push_back(32'd16384);
        exp_q.push_back(32'd24576);
        exp_q.push_back(-32'sd18704);
        do_start(0, 8192, 5);
        n_checks++;
        if (tvalid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: tvalid=%b busy=%b required 1 1", tvalid, busy);
        end
        wait_beats(5, 20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_timeout: beats=%0d required 5", beats);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done=%b tvalid=%b busy=%b required 1 0 0", done, tvalid, busy);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b required 0", done);
        end
        n_checks++;
        if (exp_q.size() != 0 || beats != 5) begin
            n_fail++;
            $display("FAIL basic_count: beats=%0d left=%0d required 5 0", beats, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall;
        int k;
        bit ok;
        tready = 1'b1;
        beats  = 0;
        ok     = 1'b0;
        push_model(0, 8192, 5);
        do_start(0, 8192, 5);
        k = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (beats >= 5) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            tready = (k % 4 == 0) || (k % 4 == 3);
            // A start while busy must not disturb the burst.
            start       = (k == 2);
            start_phase = (k == 2) ? 16'd1234 : start_phase;
            step        = (k == 2) ? 16'd1 : step;
            num_samples = (k == 2) ? 16'd2 : num_samples;
            k++;
        end
        start = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_timeout: beats=%0d required 5", beats);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done: done=%b tvalid=%b required 1 0", done, tvalid);
        end
        @(posedge clk); #1 tready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (beats != 5 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL stall_count: beats=%0d left=%0d required 5 0", beats, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_len;
        bit saw_valid;
        tready    = 1'b1;
        beats     = 0;
        saw_valid = 1'b0;
        do_start(500, 10, 0);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: done=%b busy=%b required 1 0", done, busy);
        end
        saw_valid = saw_valid | tvalid;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done_pulse: done=%b required 0", done);
        end
        for (int i = 0; i < 5; i++) begin
            saw_valid = saw_valid | tvalid;
            @(negedge clk);
        end
        n_checks++;
        if (saw_valid !== 1'b0 || beats != 0) begin
            n_fail++;
            $display("FAIL zero_no_valid: tvalid_seen=%b beats=%0d required 0 0", saw_valid, beats);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort;
        bit ok;
        bit stuck;
        tready = 1'b1;
        beats  = 0;
        stuck  = 1'b0;
        push_model(30000, 1000, 3);
        do_start(30000, 1000, 100);
        n_checks++;
        if (tdata !== 32'd25736) begin
            n_fail++;
            $display("FAIL abort_sat: tdata=%0d required 25736", $signed(tdata));
        end
        wait_beats(2, 20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL abort_timeout: beats=%0d required 2", beats);
        end
        @(posedge clk); #1;
        tready = 1'b0;
        abort  = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            stuck = stuck | !tvalid | done;
        end
        n_checks++;
        if (stuck !== 1'b0 || beats != 2) begin
            n_fail++;
            $display("FAIL abort_hold: lost_valid_or_done=%b beats=%0d required 0 2", stuck, beats);
        end
        @(posedge clk); #1 tready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (beats != 3) begin
            n_fail++;
            $display("FAIL abort_final_beat: beats=%0d required 3", beats);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_done: done=%b tvalid=%b busy=%b required 1 0 0", done, tvalid, busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (beats != 3 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL abort_count: beats=%0d left=%0d required 3 0", beats, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst;
        bit ok;
        tready = 1'b1;
        beats  = 0;
        push_model(0, 3000, 10);
        do_start(0, 3000, 10);
        wait_beats(2, 20, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midrst_timeout: beats=%0d required 2", beats);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (tvalid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tdata !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: tvalid=%b busy=%b done=%b tdata=%0d required 0 0 0 0", tvalid, busy, done, tdata);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        beats = 0;
        push_model(-25000, 5000, 7);
        do_start(-25000, 5000, 7);
        wait_beats(7, 30, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midrst_rerun_timeout: beats=%0d required 7", beats);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || tvalid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_rerun_done: done=%b tvalid=%b left=%0d required 1 0 0", done, tvalid, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        start_phase = '0;
        step        = '0;
        num_samples = '0;
        abort       = 1'b0;
        tready      = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_zero_len();
        test_abort();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
